updown_count_monitor: RTL

//  Receive-side companion to the up/down counter: samples the counter's Count bus and

---
 rtl/updown_pkg.sv | 22 ++
 rtl/updown_step_classifier.sv | 36 +++
 rtl/updown_count_monitor.sv | 136 +++++++++++++
 3 files changed

// File: rtl/updown_pkg.sv
// Shared definitions for the up/down counter and its receive-side monitor:
// tracking states, step classes and the default counter width.
package updown_pkg;

  localparam int COUNT_WIDTH = 6;

  typedef enum logic [2:0] {
    EMPTY,
    IDLE,
    UP,
    DOWN,
    FAULT
  } state_t;

  typedef enum logic [1:0] {
    STAY,
    INC,
    DEC,
    JUMP
  } step_t;

endpackage

// File: rtl/updown_step_classifier.sv
// Combinational classifier: compares the previous and current count samples and
// reports the modular step class plus wrap-around flags.
module updown_step_classifier
  import updown_pkg::*;
#(
  parameter int WIDTH = COUNT_WIDTH
) (
  input  logic [WIDTH-1:0] i_prev,
  input  logic [WIDTH-1:0] i_count,
  output logic [1:0]       o_step,
  output logic             o_wrapUp,
  output logic             o_wrapDown
);

  logic [WIDTH-1:0] w_diff;
  step_t            w_step;

  assign w_diff = i_count - i_prev;

  // The modulo-2^WIDTH difference falls out of plain unsigned subtraction
  always_comb begin
    w_step = JUMP;
    if (w_diff == '0) begin
      w_step = STAY;
    end else if (w_diff == WIDTH'(1)) begin
      w_step = INC;
    end else if (w_diff == '1) begin
      w_step = DEC;
    end
  end

  assign o_step     = w_step;
  assign o_wrapUp   = (w_step == INC) && (i_prev == '1);
  assign o_wrapDown = (w_step == DEC) && (i_prev == '0);

endmodule

// File: rtl/updown_count_monitor.sv
// Observes an up/down counter's output and reconstructs its direction, wrap events
// and a saturating net wrap tally; any illegal step latches a sticky fault.
module updown_count_monitor
  import updown_pkg::*;
#(
  parameter int WIDTH       = COUNT_WIDTH,
  parameter int WRAP_W      = 8,
  parameter int STALL_LIMIT = 4
) (
  input  logic              Clk,
  input  logic              reset,
  input  logic              Sample,
  input  logic [WIDTH-1:0]  CountIn,
  input  logic              ErrClear,
  output logic              Dir,
  output logic              DirValid,
  output logic              WrapUp,
  output logic              WrapDown,
  output logic              Reversal,
  output logic [WRAP_W-1:0] WrapCount,
  output logic              Fault
);

  localparam int                STALL_W    = $clog2(STALL_LIMIT + 1);
  localparam logic [STALL_W-1:0] STALL_MAX  = STALL_W'(STALL_LIMIT);
  localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(STALL_LIMIT - 1);
  localparam logic [WRAP_W-1:0]  TALLY_MAX  = {1'b0, {(WRAP_W-1){1'b1}}};
  localparam logic [WRAP_W-1:0]  TALLY_MIN  = {1'b1, {(WRAP_W-1){1'b0}}};

  state_t             r_state;
  logic [WIDTH-1:0]   r_prev;
  logic [STALL_W-1:0] r_stallCnt;
  logic [1:0]         w_stepRaw;
  step_t              w_step;
  logic               w_wrapUp;
  logic               w_wrapDown;

  updown_step_classifier #(
    .WIDTH(WIDTH)
  ) u_classifier (
    .i_prev    (r_prev),
    .i_count   (CountIn),
    .o_step    (w_stepRaw),
    .o_wrapUp  (w_wrapUp),
    .o_wrapDown(w_wrapDown)
  );

  assign w_step = step_t'(w_stepRaw);

  // Tracking FSM; every output is a register updated alongside the state
  always_ff @(posedge Clk) begin
    if (reset) begin
      r_state    <= EMPTY;
      r_prev     <= '0;
      r_stallCnt <= '0;
      Dir        <= 1'b0;
      DirValid   <= 1'b0;
      WrapUp     <= 1'b0;
      WrapDown   <= 1'b0;
      Reversal   <= 1'b0;
      WrapCount  <= '0;
      Fault      <= 1'b0;
    end else begin
      WrapUp   <= 1'b0;
      WrapDown <= 1'b0;
      Reversal <= 1'b0;
      case (r_state)
        EMPTY: begin
          if (Sample) begin
            r_prev     <= CountIn;
            r_stallCnt <= '0;
            r_state    <= IDLE;
          end
        end
        FAULT: begin
          if (Sample) begin
            r_prev <= CountIn;
          end
          if (ErrClear) begin
            Fault   <= 1'b0;
            r_state <= EMPTY;
          end
        end
        default: begin
          if (Sample) begin
            r_prev <= CountIn;
            case (w_step)
              INC: begin
                r_state    <= UP;
                r_stallCnt <= '0;
                Dir        <= 1'b1;
                DirValid   <= 1'b1;
                Reversal   <= (r_state == DOWN);
                if (w_wrapUp) begin
                  WrapUp <= 1'b1;
                  if (WrapCount != TALLY_MAX) begin
                    WrapCount <= WrapCount + WRAP_W'(1);
                  end
                end
              end
              DEC: begin
                r_state    <= DOWN;
                r_stallCnt <= '0;
                Dir        <= 1'b0;
                DirValid   <= 1'b1;
                Reversal   <= (r_state == UP);
                if (w_wrapDown) begin
                  WrapDown <= 1'b1;
                  if (WrapCount != TALLY_MIN) begin
                    WrapCount <= WrapCount - WRAP_W'(1);
                  end
                end
              end
              STAY: begin
                // The stall count parks at the limit so IDLE persists until movement resumes
                if (r_stallCnt >= STALL_LAST) begin
                  r_stallCnt <= STALL_MAX;
                  r_state    <= IDLE;
                  DirValid   <= 1'b0;
                end else begin
                  r_stallCnt <= r_stallCnt + STALL_W'(1);
                end
              end
              default: begin
                r_state  <= FAULT;
                Fault    <= 1'b1;
                DirValid <= 1'b0;
              end
            endcase
          end
        end
      endcase
    end
  end

endmodule
